// File: rtl/match_event_counter.sv
// Statistics stage behind the symbol sequence detector: counts match events, tracks run lengths,
// raises a sticky threshold alarm and offers a req/ack snapshot of the statistics.
module match_event_counter #(
    parameter int CNT_W  = 8,
    parameter int LEN_W  = 8,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ans,
    input  logic             clr,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN_W-1:0] run_len,
    output logic [LEN_W-1:0] max_len,
    output logic             alarm,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_count,
    output logic [LEN_W-1:0] snap_maxlen
);

    typedef enum logic {IDLE, HOLD} snap_state_t;

    logic             ans_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] run_q, run_d;
    logic [LEN_W-1:0] max_q, max_d;
    logic             alarm_q, alarm_d;
    snap_state_t      state_q;
    logic             snap_valid_q;
    logic [CNT_W-1:0] snap_count_q;
    logic [LEN_W-1:0] snap_maxlen_q;
    logic             rise, fall;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
        return (v == {LEN_W{1'b1}}) ? v : v + LEN_W'(1);
    endfunction

    assign rise = ans & ~ans_q;
    assign fall = ~ans & ans_q;

    always_comb begin
        count_d = count_q;
        run_d   = run_q;
        max_d   = max_q;
        alarm_d = alarm_q;
        if (clr) begin
            count_d = '0;
            run_d   = '0;
            max_d   = '0;
            alarm_d = 1'b0;
        end else begin
            if (rise) begin
                count_d = sat_inc_cnt(count_q);
            end
            // run_q is already zero whenever ans has been low, so low simply means zero
            run_d = ans ? sat_inc_len(run_q) : '0;
            if (fall && (run_q > max_q)) begin
                max_d = run_q;
            end
            if (count_d >= CNT_W'(THRESH)) begin
                alarm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ans_q   <= 1'b0;
            count_q <= '0;
            run_q   <= '0;
            max_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            ans_q   <= ans;
            count_q <= count_d;
            run_q   <= run_d;
            max_q   <= max_d;
            alarm_q <= alarm_d;
        end
    end

    // Snapshot captures pre-edge statistics, so a same-cycle rise or clr is not included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            snap_valid_q  <= 1'b0;
            snap_count_q  <= '0;
            snap_maxlen_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (snap_req) begin
                        snap_count_q  <= count_q;
                        snap_maxlen_q <= max_q;
                        snap_valid_q  <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (snap_ack) begin
                        snap_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    snap_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign match_count = count_q;
    assign run_len     = run_q;
    assign max_len     = max_q;
    assign alarm       = alarm_q;
    assign snap_valid  = snap_valid_q;
    assign snap_count  = snap_count_q;
    assign snap_maxlen = snap_maxlen_q;

endmodule

// File: tb/tb_match_event_counter.sv
// Directed-vector scoreboard bench for match_event_counter: a default 8/8/4 instance and a
// narrow 2/3/3 instance that exercises saturation.
module tb_match_event_counter;

    logic clk = 1'b0;
    logic rst_n;
    logic ans1, clr1, req1, ack1;
    logic ans2, clr2, req2, ack2;

    logic [7:0] mc1, rl1, ml1, sc1, sm1;
    logic       al1, sv1;
    logic [1:0] mc2, sc2;
    logic [2:0] rl2, ml2, sm2;
    logic       al2, sv2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit   dut;
        int   idx;
        int   cnt, run, maxl;
        logic alarm, sv;
        int   sc, sm;
    } exp_t;

    exp_t q[$];
    int   step_no = 0;

    always #5 clk = ~clk;

    match_event_counter #(.CNT_W(8), .LEN_W(8), .THRESH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ans(ans1), .clr(clr1), .snap_req(req1), .snap_ack(ack1),
        .match_count(mc1), .run_len(rl1), .max_len(ml1), .alarm(al1),
        .snap_valid(sv1), .snap_count(sc1), .snap_maxlen(sm1)
    );

    match_event_counter #(.CNT_W(2), .LEN_W(3), .THRESH(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ans(ans2), .clr(clr2), .snap_req(req2), .snap_ack(ack2),
        .match_count(mc2), .run_len(rl2), .max_len(ml2), .alarm(al2),
        .snap_valid(sv2), .snap_count(sc2), .snap_maxlen(sm2)
    );

    task automatic compare(input string name, input int idx, input int ac, input int ar,
                           input int am, input logic aa, input logic av, input int asc,
                           input int asm, input exp_t e);
        checks++;
        if (ac !== e.cnt || ar !== e.run || am !== e.maxl || aa !== e.alarm ||
            av !== e.sv || asc !== e.sc || asm !== e.sm) begin
            errors++;
            $display("FAIL %s%0d: got cnt=%0d run=%0d max=%0d alarm=%0b sv=%0b sc=%0d sm=%0d, want cnt=%0d run=%0d max=%0d alarm=%0b sv=%0b sc=%0d sm=%0d",
                     name, idx, ac, ar, am, aa, av, asc, asm,
                     e.cnt, e.run, e.maxl, e.alarm, e.sv, e.sc, e.sm);
        end
    endtask

    // Monitor: every edge that has a queued expectation is checked just after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (!e.dut)
                compare("d1_step", e.idx, int'(mc1), int'(rl1), int'(ml1), al1, sv1,
                        int'(sc1), int'(sm1), e);
            else
                compare("d2_step", e.idx, int'(mc2), int'(rl2), int'(ml2), al2, sv2,
                        int'(sc2), int'(sm2), e);
        end
    end

    task automatic step(input bit d, input logic a, input logic c, input logic r, input logic k,
                        input int ec, input int er, input int em, input logic ea,
                        input logic ev, input int esc, input int esm);
        exp_t e;
        @(negedge clk);
        ans1 = d ? 1'b0 : a;  clr1 = d ? 1'b0 : c;  req1 = d ? 1'b0 : r;  ack1 = d ? 1'b0 : k;
        ans2 = d ? a : 1'b0;  clr2 = d ? c : 1'b0;  req2 = d ? r : 1'b0;  ack2 = d ? k : 1'b0;
        step_no++;
        e.dut = d;  e.idx = step_no;
        e.cnt = ec; e.run = er; e.maxl = em; e.alarm = ea; e.sv = ev; e.sc = esc; e.sm = esm;
        q.push_back(e);
    endtask

    task automatic check_reset(input string name);
        exp_t z;
        z.dut = 1'b0; z.idx = 0;
        z.cnt = 0; z.run = 0; z.maxl = 0; z.alarm = 1'b0; z.sv = 1'b0; z.sc = 0; z.sm = 0;
        compare({name, "_d1_"}, 0, int'(mc1), int'(rl1), int'(ml1), al1, sv1,
                int'(sc1), int'(sm1), z);
        compare({name, "_d2_"}, 0, int'(mc2), int'(rl2), int'(ml2), al2, sv2,
                int'(sc2), int'(sm2), z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ans1 = 0; clr1 = 0; req1 = 0; ack1 = 0;
        ans2 = 0; clr2 = 0; req2 = 0; ack2 = 0;
        #12;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Four single-cycle pulses; alarm sets on the edge the count reaches 4
        step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 4, 1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Run of 5 then run of 2
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, 0, 1, i, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 2, 1, 5, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 2, 2, 5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 2, 0, 5, 0, 0, 0, 0);

        // Snapshot with same-cycle rise, re-request in HOLD, ack, ack in IDLE, req+ack in HOLD
        step(0, 1, 0, 1, 0, 3, 1, 5, 0, 1, 2, 5);
        step(0, 1, 0, 1, 0, 3, 2, 5, 0, 1, 2, 5);
        step(0, 0, 0, 0, 1, 3, 0, 5, 0, 0, 2, 5);
        step(0, 0, 0, 0, 1, 3, 0, 5, 0, 0, 2, 5);
        step(0, 0, 0, 1, 0, 3, 0, 5, 0, 1, 3, 5);
        step(0, 0, 0, 1, 1, 3, 0, 5, 0, 0, 3, 5);
        step(0, 0, 0, 0, 0, 3, 0, 5, 0, 0, 3, 5);

        // clr with a rise while a snapshot is held
        step(0, 0, 0, 1, 0, 3, 0, 5, 0, 1, 3, 5);
        step(0, 1, 0, 0, 0, 4, 1, 5, 1, 1, 3, 5);
        step(0, 0, 0, 0, 0, 4, 0, 5, 1, 1, 3, 5);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 3, 5);
        for (int i = 1; i <= 3; i++) step(0, 1, 0, 0, 0, 0, i, 0, 0, 1, 3, 5);
        step(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 3, 5);

        // Async reset mid-run while in HOLD, then release with ans already high
        step(0, 1, 0, 0, 0, 1, 1, 3, 0, 1, 3, 5);
        step(0, 1, 0, 0, 0, 1, 2, 3, 0, 1, 3, 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(posedge clk);
        #1;
        check_reset("rst_hold");
        #2;
        rst_n = 1'b1;
        step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);

        // Narrow instance: count saturates at 3, run length at 7
        for (int p = 1; p <= 5; p++) begin
            step(1, 1, 0, 0, 0, (p < 3) ? p : 3, 1, (p == 1) ? 0 : 1, p >= 3, 0, 0, 0);
            step(1, 0, 0, 0, 0, (p < 3) ? p : 3, 0, 1, p >= 3, 0, 0, 0);
        end
        for (int i = 1; i <= 10; i++) step(1, 1, 0, 0, 0, 3, (i < 7) ? i : 7, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3, 0, 7, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 3, 0, 7, 1, 1, 3, 7);
        step(1, 0, 0, 0, 1, 3, 0, 7, 1, 0, 3, 7);

        @(negedge clk);
        ans1 = 0; clr1 = 0; req1 = 0; ack1 = 0;
        ans2 = 0; clr2 = 0; req2 = 0; ack2 = 0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
